// File: rtl/inst_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// inst_sram_responder_pkg
// Shared definitions for the instruction-side SRAM responder:
//   - state_e      : responder FSM state encodings
//   - LFSR_SEED    : reset value of the optional stress-delay LFSR
//   - WCNT_W       : width of the wait counter (LATENCY up to 15 plus 3 extra)
//   - lfsr_next()  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
// -----------------------------------------------------------------------------
package inst_sram_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          WCNT_W    = 5;

    // Shift left, feeding back the XOR of bits 16,14,13,11 (1-based numbering).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/inst_sram_responder_fifo.sv
// -----------------------------------------------------------------------------
// inst_req_fifo
// Request queue holding RAM word addresses of accepted fetch requests.
// Pointers wrap naturally at DEPTH (power of two); count carries one extra bit
// so it spans 0..DEPTH.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push, push_data       enqueue a word address (ignored while full)
//   pop                   dequeue the head entry (ignored while empty)
//   head_data             oldest queued word address
//   count, full, empty    registered occupancy status
// -----------------------------------------------------------------------------
module inst_req_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[head_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {AW{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[tail_r] <= push_data;
                tail_r        <= tail_r + PW'(1);
            end else begin
                tail_r        <= tail_r;
            end
            if (pop_ok_s) begin
                head_r <= head_r + PW'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
// Responder end of the SRAM-like instruction bus. Queues up to DEPTH accepted
// requests, reads each from a synchronous single-port RAM after LATENCY wait
// cycles and returns the words strictly in request order.
// Optional build macro: INST_RESP_RANDOM_DELAY_EN adds 0..3 pseudo-random wait
// cycles per request (16-bit LFSR) for fetch-stage stress testing.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   inst_req        fetch requests a word
//   inst_addr       byte address; only bits [AW+1:2] are used
//   inst_addr_ok    request accepted when inst_req && inst_addr_ok
//   inst_rdata      returned word, valid with inst_data_ok (else 0)
//   inst_data_ok    one-cycle pulse per accepted request, in order
//   ram_en          RAM read enable
//   ram_addr        RAM word address (holds last value outside reads)
//   ram_rdata       RAM read data, valid the cycle after ram_en
// -----------------------------------------------------------------------------
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int AW      = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_addr_ok,
    output logic [31:0]   inst_rdata,
    output logic          inst_data_ok,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    input  logic [31:0]   ram_rdata
);

    localparam int                CW    = $clog2(DEPTH) + 1;
    localparam logic [WCNT_W-1:0] LAT_W = WCNT_W'(LATENCY);

    state_e              state_r;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [AW-1:0]       ram_addr_hold_r;
    logic [WCNT_W-1:0]   wload_s;
    logic                push_s;
    logic                pop_s;
    logic [AW-1:0]       head_data_s;
    logic [CW-1:0]       count_s;
    logic                full_s;
    logic                empty_s;
    logic                resp_more_s;
    logic                unused_addr_bits_s;

    // Byte-lane and upper address bits carry no meaning for a word RAM.
    assign unused_addr_bits_s = ^{inst_addr[31:AW+2], inst_addr[1:0]};

    // No full-bypass: a pop in the same cycle does not open acceptance.
    assign inst_addr_ok = !reset && !full_s;
    assign push_s       = inst_req && inst_addr_ok;
    assign pop_s        = (state_r == S_RESP);

    // Queue is non-empty after this cycle's pop iff another entry remains
    // or a new one is being pushed right now.
    assign resp_more_s  = (count_s > CW'(1)) || push_s;

    inst_req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (inst_addr[AW+1:2]),
        .pop       (pop_s),
        .head_data (head_data_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

`ifdef INST_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_r;

    // Free-running stress LFSR, advances every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign wload_s = LAT_W + {{(WCNT_W-2){1'b0}}, lfsr_r[1:0]};
`else
    assign wload_s = LAT_W;
`endif

    // Responder FSM working on the queue head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= S_IDLE;
            wcnt_r          <= {WCNT_W{1'b0}};
            ram_addr_hold_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!empty_s) begin
                        wcnt_r  <= wload_s;
                        state_r <= (wload_s != {WCNT_W{1'b0}}) ? S_WAIT : S_READ;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    wcnt_r <= wcnt_r - WCNT_W'(1);
                    if (wcnt_r <= WCNT_W'(1)) begin
                        state_r <= S_READ;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_READ: begin
                    ram_addr_hold_r <= head_data_s;
                    state_r         <= S_RESP;
                end
                S_RESP: begin
                    if (resp_more_s) begin
                        wcnt_r  <= wload_s;
                        state_r <= (wload_s != {WCNT_W{1'b0}}) ? S_WAIT : S_READ;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decoded from the state register; read data passes straight
    // through from the RAM during the response cycle.
    always_comb begin
        ram_en       = 1'b0;
        ram_addr     = ram_addr_hold_r;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0000_0000;
        case (state_r)
            S_READ: begin
                ram_en   = 1'b1;
                ram_addr = head_data_s;
            end
            S_RESP: begin
                inst_data_ok = 1'b1;
                inst_rdata   = ram_rdata;
            end
            default: begin
                ram_en       = 1'b0;
                inst_data_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
module tb_inst_sram_responder;

    localparam int AW = 14;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    // DUT with LATENCY=2
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_addr_ok;
    logic [31:0]   inst_rdata;
    logic          inst_data_ok;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata = 32'h0;
    // DUT with LATENCY=0
    logic          req0;
    logic [31:0]   addr0;
    logic          addr_ok0;
    logic [31:0]   rdata0;
    logic          data_ok0;
    logic          ram_en0;
    logic [AW-1:0] ram_addr0;
    logic [31:0]   ram_rdata0 = 32'h0;

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  cyc          = 0;
    int  acc0_n       = 0;
    int  dok0_n       = 0;
    ev_t exp_q[$], obs_q[$], exp0_q[$], obs0_q[$];

    always #5 clk = ~clk;

    inst_sram_responder #(.DEPTH(4), .LATENCY(2), .AW(AW)) dut (
        .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata));

    inst_sram_responder #(.DEPTH(4), .LATENCY(0), .AW(AW)) dut0 (
        .clk(clk), .reset(reset), .inst_req(req0), .inst_addr(addr0),
        .inst_addr_ok(addr_ok0), .inst_rdata(rdata0), .inst_data_ok(data_ok0),
        .ram_en(ram_en0), .ram_addr(ram_addr0), .ram_rdata(ram_rdata0));

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        if (a == 14'd4) return 32'h2408_0001;
        else            return {16'h8C00, 2'b00, a};
    endfunction

    // Cycle counter and synchronous RAM models.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en)  ram_rdata  <= word_of(ram_addr);
        if (ram_en0) ram_rdata0 <= word_of(ram_addr0);
    end

    // Scoreboard: expected word queued on accept, observed word on data_ok.
    always @(negedge clk) begin
        if (inst_req && inst_addr_ok) exp_q.push_back('{data: word_of(inst_addr[AW+1:2]), cyc: cyc});
        if (inst_data_ok)             obs_q.push_back('{data: inst_rdata, cyc: cyc});
        if (req0 && addr_ok0) begin
            exp0_q.push_back('{data: word_of(addr0[AW+1:2]), cyc: cyc});
            acc0_n <= acc0_n + 1;
        end
        if (data_ok0) begin
            obs0_q.push_back('{data: rdata0, cyc: cyc});
            dok0_n <= dok0_n + 1;
        end
    end

    task automatic test_reset();
        reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; req0 = 1'b0; addr0 = 32'h0;
        #2;
        tests_run++; if (inst_addr_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_ok: got %b want 0", inst_addr_ok); end
        tests_run++; if (inst_data_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_data_ok: got %b want 0", inst_data_ok); end
        tests_run++; if (ram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        tests_run++; if (ram_addr !== 14'd0) begin tests_failed++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        tests_run++; if (inst_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", inst_rdata); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests_run++; if (inst_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL post_reset_addr_ok: got %b want 1", inst_addr_ok); end
        tests_run++; if (addr_ok0 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_addr_ok0: got %b want 1", addr_ok0); end
    endtask

    task automatic test_single();
        int n_en = 0, n_dok = 0;
        ev_t e, o;
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h0000_0010;
        @(posedge clk); #1 inst_req = 1'b0;
        for (int rel = 1; rel <= 12; rel++) begin
            @(negedge clk);
            if (ram_en) begin
                n_en++;
                tests_run++; if (rel != 4 || ram_addr !== 14'd4) begin tests_failed++; $display("FAIL single_ram_en: at cycle %0d addr %h, want cycle 4 addr 4", rel, ram_addr); end
            end
            if (inst_data_ok) begin
                n_dok++;
                tests_run++; if (rel != 5 || inst_rdata !== 32'h2408_0001) begin tests_failed++; $display("FAIL single_data_ok: at cycle %0d rdata %h, want cycle 5 rdata 24080001", rel, inst_rdata); end
            end
        end
        tests_run++; if (n_en != 1 || n_dok != 1) begin tests_failed++; $display("FAIL single_counts: ram_en %0d data_ok %0d, want 1 and 1", n_en, n_dok); end
        tests_run++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            tests_failed++; $display("FAIL single_sb_size: exp %0d obs %0d, want 1 and 1", exp_q.size(), obs_q.size());
            exp_q.delete(); obs_q.delete();
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++; if (o.cyc - e.cyc != 5) begin tests_failed++; $display("FAIL single_latency: got %0d want 5", o.cyc - e.cyc); end
        end
    endtask

    task automatic test_burst_full();
        logic [31:0] list [6] = '{32'h0000_0100, 32'h0000_0104, 32'hFFFF_0023,
                                  32'h0000_010C, 32'h0000_0110, 32'h0000_FFFC};
        logic        okh [16];
        logic        acc;
        int          idx = 0, rel = 0;
        ev_t         e, o;
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = list[0];
        while (idx < 6 && rel < 40) begin
            @(negedge clk);
            acc = inst_req && inst_addr_ok;
            if (rel < 16) okh[rel] = inst_addr_ok;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 6) inst_addr = list[idx]; else inst_req = 1'b0;
            rel++;
        end
        inst_req = 1'b0;
        tests_run++; if (okh[3] !== 1'b1) begin tests_failed++; $display("FAIL burst_4th_accept: got %b want 1", okh[3]); end
        tests_run++; if (okh[4] !== 1'b0) begin tests_failed++; $display("FAIL burst_full_drop: got %b want 0", okh[4]); end
        tests_run++; if (okh[5] !== 1'b0) begin tests_failed++; $display("FAIL no_bypass_on_pop: got %b want 0", okh[5]); end
        tests_run++; if (okh[6] !== 1'b1) begin tests_failed++; $display("FAIL accept_after_pop: got %b want 1", okh[6]); end
        tests_run++; if (okh[7] !== 1'b0) begin tests_failed++; $display("FAIL refull_3_to_4: got %b want 0", okh[7]); end
        for (int k = 0; k < 100 && obs_q.size() < 6; k++) @(posedge clk);
        repeat (12) @(posedge clk);
        tests_run++; if (exp_q.size() != 6 || obs_q.size() != 6) begin tests_failed++; $display("FAIL burst_counts: accepts %0d data_ok %0d, want 6 and 6", exp_q.size(), obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++; if (o.data !== e.data) begin tests_failed++; $display("FAIL burst_order: got %h want %h", o.data, e.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h0000_0200;
        @(posedge clk); #1 inst_addr = 32'h0000_0204;
        @(posedge clk); #1 inst_addr = 32'h0000_0208;
        @(posedge clk); #1 inst_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests_run++; if (inst_addr_ok !== 1'b0) begin tests_failed++; $display("FAIL midreset_addr_ok: got %b want 0", inst_addr_ok); end
        tests_run++; if (ram_addr !== 14'd0) begin tests_failed++; $display("FAIL midreset_ram_addr: got %h want 0", ram_addr); end
        tests_run++; if (inst_data_ok !== 1'b0 || ram_en !== 1'b0) begin tests_failed++; $display("FAIL midreset_strobes: data_ok %b ram_en %b want 0 0", inst_data_ok, ram_en); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete(); obs_q.delete();
        repeat (12) @(posedge clk);
        tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL stale_data_ok: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h0000_0010;
        @(posedge clk); #1 inst_req = 1'b0;
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) @(posedge clk);
        tests_run++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            tests_failed++; $display("FAIL post_reset_resp: obs %0d exp %0d want 1 and 1", obs_q.size(), exp_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++; if (o.cyc - e.cyc != 5 || o.data !== 32'h2408_0001) begin tests_failed++; $display("FAIL post_reset_latency: lat %0d data %h want 5 24080001", o.cyc - e.cyc, o.data); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back_lat0();
        ev_t e, o;
        int  prev = 0;
        logic acc;
        int  idx = 0;
        @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h0000_0040;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            @(negedge clk); acc = req0 && addr_ok0;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 4) addr0 = 32'h0000_0040 + 32'(idx * 4); else req0 = 1'b0;
        end
        req0 = 1'b0;
        for (int k = 0; k < 40 && obs0_q.size() < 4; k++) @(posedge clk);
        tests_run++; if (obs0_q.size() != 4 || exp0_q.size() != 4) begin tests_failed++; $display("FAIL lat0_counts: obs %0d exp %0d want 4 and 4", obs0_q.size(), exp0_q.size()); end
        for (int i = 0; i < 4 && obs0_q.size() > 0 && exp0_q.size() > 0; i++) begin
            e = exp0_q.pop_front(); o = obs0_q.pop_front();
            tests_run++; if (o.data !== e.data) begin tests_failed++; $display("FAIL lat0_data: got %h want %h", o.data, e.data); end
            tests_run++;
            if (i == 0) begin
                if (o.cyc - e.cyc != 3) begin tests_failed++; $display("FAIL lat0_first_latency: got %0d want 3", o.cyc - e.cyc); end
            end else if (o.cyc - prev != 2) begin
                tests_failed++; $display("FAIL lat0_spacing: got %0d want 2", o.cyc - prev);
            end
            prev = o.cyc;
        end
        exp0_q.delete(); obs0_q.delete();
    endtask

    task automatic test_random_delay();
        ev_t e, o;
        int  bad_lat = 0, bad_data = 0, lost = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1 req0 = 1'b1; addr0 = $urandom;
            @(posedge clk); #1 req0 = 1'b0;
            for (int k = 0; k < 20 && obs0_q.size() < 1; k++) @(posedge clk);
            if (obs0_q.size() < 1 || exp0_q.size() < 1) begin
                lost++;
                exp0_q.delete(); obs0_q.delete();
            end else begin
                e = exp0_q.pop_front(); o = obs0_q.pop_front();
                if (o.cyc - e.cyc < 3 || o.cyc - e.cyc > 6) begin
                    bad_lat++; $display("FAIL rand_latency: got %0d want 3..6", o.cyc - e.cyc);
                end
                if (o.data !== e.data) begin
                    bad_data++; $display("FAIL rand_order: got %h want %h", o.data, e.data);
                end
            end
        end
        repeat (10) @(posedge clk);
        tests_run++; if (bad_lat != 0) begin tests_failed++; $display("FAIL rand_latency_total: got %0d bad want 0", bad_lat); end
        tests_run++; if (bad_data != 0) begin tests_failed++; $display("FAIL rand_order_total: got %0d bad want 0", bad_data); end
        tests_run++; if (lost != 0) begin tests_failed++; $display("FAIL rand_timeout: got %0d want 0", lost); end
        tests_run++; if (acc0_n != dok0_n || acc0_n < 1000) begin tests_failed++; $display("FAIL rand_counts: accepts %0d data_ok %0d want equal >= 1000", acc0_n, dok0_n); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifdef INST_RESP_RANDOM_DELAY_EN
        test_random_delay();
`else
        test_single();
        test_burst_full();
        test_reset_mid();
        test_back_to_back_lat0();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Slave/responder end of the SRAM-like instruction bus (inst_req / inst_addr / inst_addr_ok, plus inst_rdata / inst_data_ok) driven by the fetch stage.
- Accepts address requests and queues up to DEPTH outstanding requests.
- Reads each queued word from a synchronous single-port instruction RAM after a programmable wait.
- Returns data strictly in request order, one word per inst_data_ok pulse.
- Used as the instruction-side memory model / on-chip boot RAM front end.

Parameters:
DEPTH, 4, maximum outstanding accepted requests (power of two, 2..16)
LATENCY, 2, extra wait cycles per request between dequeue and RAM read (0..15)
AW, 14, RAM word-address width; ram_addr = inst_addr[AW+1:2]

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch requests an instruction word
inst_addr  in  32  physical byte address of request
inst_addr_ok  out  1  request accepted this cycle when inst_req && inst_addr_ok
inst_rdata  out  32  returned instruction word, valid when inst_data_ok
inst_data_ok  out  1  one-cycle pulse per accepted request, in order
ram_en  out  1  RAM read enable
ram_addr  out  AW  RAM word address
ram_rdata  in  32  RAM data, valid the cycle after ram_en

Behaviour:
- Clock/reset: single clock clk; reset is asynchronous, active-high, port named reset.
- Reset:
  - FIFO is empty (count=0, head=tail=0); FSM is in S_IDLE; wait counter is 0.
  - inst_addr_ok=0 while reset is high. inst_data_ok=0, ram_en=0, ram_addr=0, inst_rdata=0.
  - Reset mid-operation drops all outstanding requests; no data_ok is issued for them.
- Acceptance:
  - inst_addr_ok = !reset && count<DEPTH. It is combinational from registered state only and never depends on inst_req.
  - On an accept edge, inst_addr[AW+1:2] is pushed. inst_addr[1:0] and the upper bits are ignored.
  - There is no full-bypass: while full, addr_ok=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle is allowed when not full; count is unchanged.
- FSM, operating on the FIFO head:
  - S_IDLE: if count!=0, load wcnt=LATENCY. Go to S_WAIT if LATENCY!=0, else S_READ.
  - S_WAIT: wcnt decrements each cycle; when wcnt==1, go to S_READ.
  - S_READ: ram_en=1, ram_addr=head entry. Next state is S_RESP.
  - S_RESP: inst_data_ok=1, inst_rdata=ram_rdata (combinational passthrough), pop head.
    - If count-after-pop (including a same-cycle push) is !=0, reload wcnt and go to S_WAIT/S_READ as in S_IDLE.
    - Otherwise go to S_IDLE.
- Outside S_RESP: inst_data_ok=0 and inst_rdata=0. Outside S_READ: ram_en=0 and ram_addr holds its last value.
- Latency: request accepted at edge of cycle 0 → data_ok in cycle LATENCY+3 from an idle FIFO.
- Back-to-back throughput: one word per LATENCY+2 cycles.
- There is no data-side backpressure. The fetch stage must always accept data_ok, including for cancelled instructions.
- The count and pointers use a wrap-around of DEPTH with an extra count bit; count range is 0..DEPTH.

Optional Feature:
- Macro INST_RESP_RANDOM_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1 at reset, taps 16,14,13,11) advances every cycle.
  - Each wcnt load becomes LATENCY + lfsr[1:0], i.e. 0..3 extra cycles, for fetch-stage stress testing. Order is still preserved.
- When undefined: wait is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Shared package/header common.vh gains state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_READ=2'd2, S_RESP=2'd3, and the LFSR seed constant.
- One sub-module, inst_req_fifo:
  - Parameterised DEPTH/AW.
  - Ports: push, push_data, pop, head_data, count, full, empty.
  - The top-level holds the FSM, wait counter, LFSR and bus outputs.

Test Plan:
- Single request, LATENCY=2, RAM word[4]=32'h2408_0001, addr 32'h0000_0010 at cycle 0 → ram_en/ram_addr=4 in cycle 4; data_ok with rdata 32'h2408_0001 in cycle 5 only.
- Held inst_req with 6 sequential addresses, DEPTH=4, no pops yet → addr_ok drops after the 4th accept; data returns in address order.
- Every accept is matched by exactly one data_ok.
- Full FIFO, pop in S_RESP with inst_req high → no accept that cycle; accept occurs the next cycle with count=3→4.
- Reset asserted asynchronously between clock edges with 3 requests outstanding in S_WAIT → outputs go to zero immediately.
- After release, no stale data_ok appears and the first new request returns after LATENCY+3 cycles.
- LATENCY=0, back-to-back requests → data_ok every 2 cycles.
- With INST_RESP_RANDOM_DELAY_EN, over 1000 requests:
  - in-order data
  - per-request latency in [3,6]
  - data_ok count equals accept count
